// File: rtl/decodificador_pulsacion.sv
// Push-button event decoder: press/release/short/long pulses, held level and press counter.
// Optional auto-repeat while held long is enabled by defining AUTO_REPEAT_EN.
module decodificador_pulsacion #(
    parameter int unsigned LONG_CYCLES   = 27_000_000,
    parameter int unsigned REPEAT_CYCLES = 5_400_000,
    parameter int unsigned CNT_W         = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entradaLimpia,
    output logic       pulsoPresion,
    output logic       pulsoSoltar,
    output logic       pulsoCorto,
    output logic       pulsoLargo,
    output logic       pulsoRepeticion,
    output logic       mantenido,
    output logic [7:0] contadorPulsaciones
);

    typedef enum logic [1:0] {StIdle, StPresionado, StLargo} estado_t;

    localparam logic [CNT_W-1:0] LongLim = CNT_W'(LONG_CYCLES - 1);

    estado_t          estado_q, estado_d;
    logic             entrada_q;
    logic [CNT_W-1:0] contador_q, contador_d;
    logic [7:0]       cuenta_q, cuenta_d;
    logic             presion_q, presion_d;
    logic             soltar_q, soltar_d;
    logic             corto_q, corto_d;
    logic             largo_q, largo_d;
    logic             mantenido_q, mantenido_d;

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RepLim = CNT_W'(REPEAT_CYCLES);
    logic repeticion_q, repeticion_d;
`endif

    always_comb begin
        estado_d   = estado_q;
        contador_d = contador_q;
        cuenta_d   = cuenta_q;
        presion_d  = 1'b0;
        soltar_d   = 1'b0;
        corto_d    = 1'b0;
        largo_d    = 1'b0;
`ifdef AUTO_REPEAT_EN
        repeticion_d = 1'b0;
`endif
        unique case (estado_q)
            StIdle: begin
                if (entradaLimpia && !entrada_q) begin
                    estado_d   = StPresionado;
                    presion_d  = 1'b1;
                    cuenta_d   = cuenta_q + 8'd1;
                    contador_d = CNT_W'(1);
                end
            end
            StPresionado: begin
                // Release takes priority over reaching the long threshold.
                if (!entradaLimpia) begin
                    estado_d = StIdle;
                    soltar_d = 1'b1;
                    corto_d  = 1'b1;
                end else if (contador_q == LongLim) begin
                    estado_d   = StLargo;
                    largo_d    = 1'b1;
                    contador_d = CNT_W'(1);
                end else begin
                    contador_d = contador_q + CNT_W'(1);
                end
            end
            StLargo: begin
                if (!entradaLimpia) begin
                    estado_d = StIdle;
                    soltar_d = 1'b1;
                end
`ifdef AUTO_REPEAT_EN
                else if (contador_q == RepLim) begin
                    repeticion_d = 1'b1;
                    contador_d   = CNT_W'(1);
                end else begin
                    contador_d = contador_q + CNT_W'(1);
                end
`endif
            end
            default: estado_d = StIdle;
        endcase
        mantenido_d = (estado_d == StLargo);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            estado_q    <= StIdle;
            // Start as "pressed" so a button held through reset needs a release first.
            entrada_q   <= 1'b1;
            contador_q  <= '0;
            cuenta_q    <= '0;
            presion_q   <= 1'b0;
            soltar_q    <= 1'b0;
            corto_q     <= 1'b0;
            largo_q     <= 1'b0;
            mantenido_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            entrada_q   <= entradaLimpia;
            contador_q  <= contador_d;
            cuenta_q    <= cuenta_d;
            presion_q   <= presion_d;
            soltar_q    <= soltar_d;
            corto_q     <= corto_d;
            largo_q     <= largo_d;
            mantenido_q <= mantenido_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            repeticion_q <= 1'b0;
        end else begin
            repeticion_q <= repeticion_d;
        end
    end

    assign pulsoRepeticion = repeticion_q;
`else
    assign pulsoRepeticion = 1'b0;
`endif

    assign pulsoPresion        = presion_q;
    assign pulsoSoltar         = soltar_q;
    assign pulsoCorto          = corto_q;
    assign pulsoLargo          = largo_q;
    assign mantenido           = mantenido_q;
    assign contadorPulsaciones = cuenta_q;

endmodule

// File: tb/tb_decodificador_pulsacion.sv
// Scoreboard bench for decodificador_pulsacion: stimulus queues expected events with cycle stamps,
// a monitor compares every observed pulse or mantenido change against the queue head.
`timescale 1ns/100ps
module tb_decodificador_pulsacion;

    localparam int unsigned LONG_C = 20;
    localparam int unsigned REP_C  = 5;
`ifdef AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] stamp;
        logic        pres;
        logic        solt;
        logic        corto;
        logic        largo;
        logic        rep;
        logic        mant;
        logic [7:0]  cnt;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       entrada = 1'b1;
    logic       p_pres, p_solt, p_corto, p_largo, p_rep, mant;
    logic [7:0] cnt;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    logic mant_prev = 1'b0;
    logic [7:0] cnt_m = 8'd0;
    ev_t  q[$];

    decodificador_pulsacion #(
        .LONG_CYCLES  (LONG_C),
        .REPEAT_CYCLES(REP_C),
        .CNT_W        (8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .entradaLimpia      (entrada),
        .pulsoPresion       (p_pres),
        .pulsoSoltar        (p_solt),
        .pulsoCorto         (p_corto),
        .pulsoLargo         (p_largo),
        .pulsoRepeticion    (p_rep),
        .mantenido          (mant),
        .contadorPulsaciones(cnt)
    );

    always #18.5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int stamp, input logic pr, input logic so, input logic co,
                        input logic la, input logic re, input logic ma, input logic [7:0] c);
        ev_t e;
        e.stamp = 32'(stamp);
        e.pres = pr; e.solt = so; e.corto = co; e.largo = la; e.rep = re; e.mant = ma;
        e.cnt = c;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Press held for h sampling edges, then released; gap idle cycles afterwards.
    task automatic press(input int h, input int gap);
        int e;
        @(negedge clk);
        entrada = 1'b1;
        e = cyc + 1;
        cnt_m = cnt_m + 8'd1;
        push(e, 1, 0, 0, 0, 0, 0, cnt_m);
        if (h <= int'(LONG_C) - 1) begin
            push(e + h, 0, 1, 1, 0, 0, 0, cnt_m);
        end else begin
            push(e + int'(LONG_C) - 1, 0, 0, 0, 1, 0, 1, cnt_m);
            if (REP_EN)
                for (int t = e + int'(LONG_C) - 1 + int'(REP_C); t < e + h; t += int'(REP_C))
                    push(t, 0, 0, 0, 0, 1, 1, cnt_m);
            push(e + h, 0, 1, 0, 0, 0, 0, cnt_m);
        end
        repeat (h) @(negedge clk);
        entrada = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin : monitor
        ev_t act, exp_e;
        forever begin
            @(negedge clk);
            if (mon_en && (p_pres || p_solt || p_corto || p_largo || p_rep || (mant !== mant_prev))) begin
                act.stamp = 32'(cyc);
                act.pres = p_pres; act.solt = p_solt; act.corto = p_corto;
                act.largo = p_largo; act.rep = p_rep; act.mant = mant; act.cnt = cnt;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event: got %h expected none", act);
                end else begin
                    exp_e = q.pop_front();
                    if (act !== exp_e) begin
                        bad++;
                        $display("FAIL event: got %h expected %h", act, exp_e);
                    end
                end
            end
            mant_prev = mant;
        end
    end

    initial begin : watchdog
        #(37 * 5000);
        $display("FAIL watchdog: time limit reached, pending=%0d", q.size());
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int e;
        // Reset with button held.
        rst = 1'b0;
        entrada = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("rst_presion", {7'd0, p_pres}, 8'd0);
        check("rst_soltar", {7'd0, p_solt}, 8'd0);
        check("rst_corto", {7'd0, p_corto}, 8'd0);
        check("rst_largo", {7'd0, p_largo}, 8'd0);
        check("rst_repeticion", {7'd0, p_rep}, 8'd0);
        check("rst_mantenido", {7'd0, mant}, 8'd0);
        check("rst_contador", cnt, 8'd0);
        mant_prev = 1'b0;
        mon_en = 1'b1;
        // Held through reset, then fall: no events expected.
        repeat (3) @(negedge clk);
        entrada = 1'b0;
        repeat (3) @(negedge clk);
        press(3, 4);
        // Short press.
        press(5, 4);
        // Long press with possible repeats.
        press(40, 4);
        // Release on the long-threshold edge.
        press(int'(LONG_C) - 1, 4);
        // Reset while in the long state.
        @(negedge clk);
        entrada = 1'b1;
        e = cyc + 1;
        cnt_m = cnt_m + 8'd1;
        push(e, 1, 0, 0, 0, 0, 0, cnt_m);
        push(e + int'(LONG_C) - 1, 0, 0, 0, 1, 0, 1, cnt_m);
        repeat (21) @(negedge clk);
        rst = 1'b0;
        cnt_m = 8'd0;
        push(e + 21, 0, 0, 0, 0, 0, 0, cnt_m);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        entrada = 1'b0;
        repeat (3) @(negedge clk);
        check("contador_after_reset", cnt, 8'd0);
        // Counter wrap: 256 presses back to 0, then one more gives 1.
        for (int i = 0; i < 256; i++) press(2, 2);
        repeat (3) @(negedge clk);
        check("contador_wrap", cnt, 8'd0);
        press(2, 2);
        repeat (3) @(negedge clk);
        check("contador_257", cnt, 8'd1);
        repeat (10) @(negedge clk);
        while (q.size() != 0) begin
            ev_t m;
            m = q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_event: got none expected %h", m);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
